// File: rtl/parking_pkg.sv
// parking_pkg
// Shared constants and helpers for the parking occupancy counter.
// Holds the default capacity, the counter-width derivation, the BCD
// digit width and the reset digits for the default capacity.
package parking_pkg;

  localparam int BCD_W            = 4;
  localparam int CAPACITY_DEFAULT = 20;
  localparam int CW_DEFAULT       = 7;

  // Narrowest counter width that can hold 0..cap.
  function automatic int cw_min(input int cap);
    return $clog2(cap + 1);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_tens(input int v);
    return BCD_W'(v / 10);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_ones(input int v);
    return BCD_W'(v % 10);
  endfunction

  localparam logic [BCD_W-1:0] CAP_TENS = bcd_tens(CAPACITY_DEFAULT);
  localparam logic [BCD_W-1:0] CAP_ONES = bcd_ones(CAPACITY_DEFAULT);

endpackage

// File: rtl/parking_occupancy_counter_bcd_digit_updown.sv
// bcd_digit_updown
// One BCD digit (0..9) that counts up or down in a chained BCD counter.
// Ports:
//   clk, rst             clock, async active-high reset (loads RST_VAL)
//   up, down             request a step of the whole counter
//   carry_in, borrow_in  this digit steps only when the lower digit wraps
//                        (tie to 1 for the least significant digit)
//   digit                current digit value
//   carry_out            this digit wraps 9 -> 0 on an up step
//   borrow_out           this digit wraps 0 -> 9 on a down step
module bcd_digit_updown
  import parking_pkg::*;
#(
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             step_up, step_dn;

  assign step_up = up & carry_in;
  assign step_dn = down & borrow_in;

  always_comb begin
    digit_d = digit_q;
    if (step_up) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (step_dn) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= RST_VAL;
    else     digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign carry_out  = step_up & (digit_q == 4'd9);
  assign borrow_out = step_dn & (digit_q == 4'd0);

endmodule

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
// Counts parked cars from the direction FSM's entry (S) and exit (R)
// strobes. Keeps occupied/free counts in binary plus a lockstep BCD copy
// of the free count for the display, full/empty flags and sticky
// over/underflow flags. All outputs are registered.
// Ports:
//   clk, rst             clock, async active-high reset
//   S, R                 entry / exit strobes (rising edge counts once)
//   err_clr              synchronous clear of the sticky error flags
//   count, free          occupied and free spaces (count + free == CAPACITY)
//   free_tens, free_ones BCD digits of free
//   full, empty          count == CAPACITY / count == 0
//   err_over, err_under  entry while full / exit while empty (sticky)
// CW must satisfy 2**CW > CAPACITY (see parking_pkg::cw_min).
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  input  logic             R,
  input  logic             err_clr,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free,
  output logic [BCD_W-1:0] free_tens,
  output logic [BCD_W-1:0] free_ones,
  output logic             full,
  output logic             empty,
  output logic             err_over,
  output logic             err_under
);

  localparam logic [CW-1:0]    CAP_W    = CW'(CAPACITY);
  localparam logic [BCD_W-1:0] RST_TENS = bcd_tens(CAPACITY);
  localparam logic [BCD_W-1:0] RST_ONES = bcd_ones(CAPACITY);

  logic          s_q, r_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          err_over_q, err_over_d;
  logic          err_under_q, err_under_d;

  logic inc, dec;
  logic inc_ok, dec_ok;
  logic over_evt, under_evt;
  logic ones_carry, ones_borrow;
  logic tens_carry_unused, tens_borrow_unused;

  // s_q/r_q reset high so a strobe already asserted at reset release
  // is not mistaken for a fresh edge.
  assign inc = S & ~s_q;
  assign dec = R & ~r_q;

  // Simultaneous entry and exit cancel: no count change and no error.
  assign inc_ok    = inc & ~dec & ~full_q;
  assign dec_ok    = dec & ~inc & ~empty_q;
  assign over_evt  = inc & ~dec &  full_q;
  assign under_evt = dec & ~inc &  empty_q;

  always_comb begin
    count_d = count_q;
    free_d  = free_q;
    if (inc_ok) begin
      count_d = count_q + CW'(1);
      free_d  = free_q  - CW'(1);
    end else if (dec_ok) begin
      count_d = count_q - CW'(1);
      free_d  = free_q  + CW'(1);
    end
    full_d      = (count_d == CAP_W);
    empty_d     = (count_d == '0);
    // Set has priority over a same-cycle clear.
    err_over_d  = over_evt  | (err_over_q  & ~err_clr);
    err_under_d = under_evt | (err_under_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= 1'b1;
      r_q         <= 1'b1;
      count_q     <= '0;
      free_q      <= CAP_W;
      full_q      <= (CAPACITY == 0);
      empty_q     <= 1'b1;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      s_q         <= S;
      r_q         <= R;
      count_q     <= count_d;
      free_q      <= free_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

  // BCD copy of free: counts up on an accepted exit, down on an accepted entry.
  bcd_digit_updown #(.RST_VAL(RST_ONES)) u_ones (
    .clk        (clk),
    .rst        (rst),
    .up         (dec_ok),
    .down       (inc_ok),
    .carry_in   (1'b1),
    .borrow_in  (1'b1),
    .digit      (free_ones),
    .carry_out  (ones_carry),
    .borrow_out (ones_borrow)
  );

  bcd_digit_updown #(.RST_VAL(RST_TENS)) u_tens (
    .clk        (clk),
    .rst        (rst),
    .up         (dec_ok),
    .down       (inc_ok),
    .carry_in   (ones_carry),
    .borrow_in  (ones_borrow),
    .digit      (free_tens),
    .carry_out  (tens_carry_unused),
    .borrow_out (tens_borrow_unused)
  );

  assign count     = count_q;
  assign free      = free_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err_over  = err_over_q;
  assign err_under = err_under_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;

  localparam int CAP = 20;
  localparam int CW  = 7;

  logic          clk = 1'b0;
  logic          rst, S, R, err_clr;
  logic [CW-1:0] count, free;
  logic [3:0]    free_tens, free_ones;
  logic          full, empty, err_over, err_under;

  int n_vec = 0;
  int n_mis = 0;

  parking_occupancy_counter #(.CAPACITY(CAP), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .S         (S),
    .R         (R),
    .err_clr   (err_clr),
    .count     (count),
    .free      (free),
    .free_tens (free_tens),
    .free_ones (free_ones),
    .full      (full),
    .empty     (empty),
    .err_over  (err_over),
    .err_under (err_under)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output check against a hand-supplied car count and error flags.
  task automatic chk_state(input string tag, input int c, input logic eo, input logic eu);
    int f;
    f = CAP - c;
    chk({tag, ".count"},     32'(count),     32'(c));
    chk({tag, ".free"},      32'(free),      32'(f));
    chk({tag, ".tens"},      32'(free_tens), 32'(f / 10));
    chk({tag, ".ones"},      32'(free_ones), 32'(f % 10));
    chk({tag, ".full"},      32'(full),      32'(c == CAP));
    chk({tag, ".empty"},     32'(empty),     32'(c == 0));
    chk({tag, ".err_over"},  32'(err_over),  32'(eo));
    chk({tag, ".err_under"}, 32'(err_under), 32'(eu));
  endtask

  task automatic pulse_s();
    S = 1'b1; tick();
    S = 1'b0; tick();
  endtask

  task automatic pulse_r();
    R = 1'b1; tick();
    R = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; S = 1'b0; R = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk_state("in_reset", 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_state("reset", 0, 1'b0, 1'b0);

    // Three single pulses, then one long strobe counting once.
    pulse_s(); pulse_s(); pulse_s();
    chk_state("three_s", 3, 1'b0, 1'b0);
    S = 1'b1;
    tick();
    chk_state("held_first", 4, 1'b0, 1'b0);
    repeat (4) tick();
    S = 1'b0; tick();
    chk_state("held_5", 4, 1'b0, 1'b0);

    // Cross free 10 -> 9 (tens borrow) on the way up.
    repeat (6) pulse_s();
    chk_state("at10", 10, 1'b0, 1'b0);
    pulse_s();
    chk_state("free9", 11, 1'b0, 1'b0);

    // Fill to capacity, then overflow.
    repeat (9) pulse_s();
    chk_state("full", 20, 1'b0, 1'b0);
    pulse_s();
    chk_state("overflow", 20, 1'b1, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk_state("clr_over", 20, 1'b0, 1'b0);

    // Overflow in the same cycle as err_clr: set wins.
    S = 1'b1; err_clr = 1'b1; tick();
    S = 1'b0; err_clr = 1'b0;
    chk_state("set_wins", 20, 1'b1, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk_state("clr_again", 20, 1'b0, 1'b0);

    // Down to 10, then 10 -> 9 -> 10 through the BCD carry/borrow.
    repeat (10) pulse_r();
    chk_state("down10", 10, 1'b0, 1'b0);
    pulse_r();
    chk_state("r_to9", 9, 1'b0, 1'b0);
    pulse_s();
    chk_state("s_to10", 10, 1'b0, 1'b0);
    pulse_s();
    chk_state("s_to11", 11, 1'b0, 1'b0);
    pulse_r();
    chk_state("r_to10", 10, 1'b0, 1'b0);

    // Empty, then underflow.
    repeat (10) pulse_r();
    chk_state("empty", 0, 1'b0, 1'b0);
    pulse_r();
    chk_state("underflow", 0, 1'b0, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk_state("clr_under", 0, 1'b0, 1'b0);

    // S and R rising together at empty: no change, no error.
    S = 1'b1; R = 1'b1; tick();
    S = 1'b0; R = 1'b0; tick();
    chk_state("both_empty", 0, 1'b0, 1'b0);

    // Same at a non-zero count.
    pulse_s();
    S = 1'b1; R = 1'b1; tick();
    S = 1'b0; R = 1'b0; tick();
    chk_state("both_one", 1, 1'b0, 1'b0);

    // Reset mid-operation while S is high.
    repeat (6) pulse_s();
    chk_state("at7", 7, 1'b0, 1'b0);
    S = 1'b1; rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk_state("rst_s_high", 0, 1'b0, 1'b0);
    S = 1'b0; tick();
    S = 1'b1; tick();
    chk_state("after_rst_edge", 1, 1'b0, 1'b0);
    S = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
